store_buffer: RTL and testbench

// - Write buffer between the MEM-stage pipeline register and datamemory; sits directly upstream of it.
// - Accepts SB/SH/SW from the pipeline in one cycle and drains them one per cycle to datamemory.
// - Arbitrates datamemory's single address port between loads and drains; stalls loads overlapping a pending store.
// - sb_empty gives fence/halt logic a drain-complete indication.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/store_buffer_fifo.sv | 71 +++++++
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory side of the pipeline.
// Provides the store-buffer entry layout, funct3 encodings for byte/half/word
// accesses and an access-size helper used by the overlap compare.
package mem_pkg;

  localparam int unsigned SbAddrW = 9;
  localparam int unsigned SbDataW = 32;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  typedef struct packed {
    logic [SbAddrW-1:0] addr;
    logic [SbDataW-1:0] data;
    logic [2:0]         funct3;
  } sb_entry_t;

  // Access size in bytes; the low two funct3 bits encode size for loads and stores.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO holding pending stores.
// Ports: clk/reset (sync, active-high); push/wdata enqueue; pop dequeues the head;
// head is the oldest entry; entries/valid expose every slot for the overlap compare;
// full/empty status.
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  sb_entry_t             wdata,
  input  logic                  pop,
  output sb_entry_t             head,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  push_en, pop_en;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;
  assign valid   = valid_q;

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the MEM-stage pipeline register and datamemory.
// Ports: clk/reset (sync, active-high); st_* store request with st_ready;
// ld_* load request with ld_stall; sb_empty drain-complete flag;
// dm_* drive datamemory's single address port (load read or store drain).
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [DM_ADDRESS-1:0] st_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [2:0]            st_funct3,
  input  logic                  ld_req,
  input  logic [DM_ADDRESS-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  ld_stall,
  output logic                  sb_empty,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [2:0]            dm_Funct3
);

  // Ranges use two extra bits so addr+size-1 never wraps near the top of memory.
  localparam int unsigned RangeW = DM_ADDRESS + 2;

  sb_entry_t             wdata, head;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid, hit;
  logic                  full, empty, conflict, drain;
  logic [RangeW-1:0]     ld_lo, ld_hi;

  assign wdata = '{addr: st_addr, data: st_data, funct3: st_funct3};

  store_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (st_valid && st_ready),
    .wdata   (wdata),
    .pop     (drain),
    .head    (head),
    .entries (entries),
    .valid   (valid),
    .full    (full),
    .empty   (empty)
  );

  assign st_ready = !full;
  assign sb_empty = empty;

  assign ld_lo = RangeW'(ld_addr);
  assign ld_hi = ld_lo + RangeW'(access_size(ld_funct3)) - RangeW'(1);

  // Only registered entries are compared, so a store accepted this cycle never stalls a load.
  for (genvar i = 0; i < DEPTH; i++) begin : g_overlap
    logic [RangeW-1:0] st_lo, st_hi;
    assign st_lo  = RangeW'(entries[i].addr);
    assign st_hi  = st_lo + RangeW'(access_size(entries[i].funct3)) - RangeW'(1);
    assign hit[i] = valid[i] && (st_lo <= ld_hi) && (ld_lo <= st_hi);
  end

  assign conflict = ld_req && (|hit);

  always_comb begin
    drain       = 1'b0;
    ld_stall    = 1'b0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_Funct3   = '0;
    if (full) begin
      drain    = 1'b1;
      ld_stall = ld_req;
    end else if (conflict) begin
      drain    = 1'b1;
      ld_stall = 1'b1;
    end else if (ld_req) begin
      dm_MemRead = 1'b1;
      dm_a       = ld_addr;
      dm_Funct3  = ld_funct3;
    end else if (!empty) begin
      drain = 1'b1;
    end
    // Suppress the write during reset so pending stores are discarded, not committed.
    if (drain && !reset) begin
      dm_MemWrite = 1'b1;
      dm_a        = head.addr;
      dm_wd       = head.data;
      dm_Funct3   = head.funct3;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        ld_req;
  logic [8:0]  ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_stall, sb_empty, dm_MemRead, dm_MemWrite;
  logic [8:0]  dm_a;
  logic [31:0] dm_wd;
  logic [2:0]  dm_Funct3;

  store_buffer #(
    .DM_ADDRESS (9),
    .DATA_W     (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_funct3   (st_funct3),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_funct3   (ld_funct3),
    .ld_stall    (ld_stall),
    .sb_empty    (sb_empty),
    .dm_MemRead  (dm_MemRead),
    .dm_MemWrite (dm_MemWrite),
    .dm_a        (dm_a),
    .dm_wd       (dm_wd),
    .dm_Funct3   (dm_Funct3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } ent_t;

  ent_t       q[$];      // pending stores, oldest first
  logic [7:0] dmem[512]; // datamemory as written by the DUT port
  logic [7:0] gmem[512]; // memory as the reference model says it should be
  int         tests = 0;
  int         fails = 0;

  function automatic int sz(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Byte-by-byte set intersection against every pending store.
  function automatic bit overlaps(input int la, input int lsz);
    foreach (q[i]) begin
      for (int s = 0; s < sz(q[i].f3); s++) begin
        for (int l = 0; l < lsz; l++) begin
          if (q[i].addr + s == la + l) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit_dut_write(input bit we, input logic [8:0] a, input logic [31:0] wd,
                                  input logic [2:0] f3);
    if (we) begin
      for (int k = 0; k < sz(f3); k++) begin
        if (int'(a) + k < 512) dmem[int'(a) + k] = wd[8*k +: 8];
      end
    end
  endtask

  task automatic step(input bit sv, input int sa, input logic [31:0] sd, input logic [2:0] sf,
                      input bit lr, input int la, input logic [2:0] lf);
    bit          full, conf, drain, rd, push;
    int          ea;
    logic [31:0] ewd;
    logic [2:0]  ef3;
    bit          we;
    logic [8:0]  wa;
    logic [31:0] wwd;
    logic [2:0]  wf3;
    @(negedge clk);
    st_valid  = sv;
    st_addr   = 9'(sa);
    st_data   = sd;
    st_funct3 = sf;
    ld_req    = lr;
    ld_addr   = 9'(la);
    ld_funct3 = lf;
    #1;
    full  = (q.size() == DEPTH);
    conf  = lr && overlaps(la, sz(lf));
    drain = full || conf || (!lr && q.size() != 0);
    rd    = lr && !full && !conf;
    push  = sv && !full;
    ea    = drain ? q[0].addr : (rd ? la : 0);
    ewd   = drain ? q[0].data : 32'h0;
    ef3   = drain ? q[0].f3 : (rd ? lf : 3'b000);
    chk("st_ready", 32'(st_ready), 32'(!full));
    chk("ld_stall", 32'(ld_stall), 32'(lr && (full || conf)));
    chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    chk("dm_MemRead", 32'(dm_MemRead), 32'(rd));
    chk("dm_MemWrite", 32'(dm_MemWrite), 32'(drain));
    chk("dm_a", 32'(dm_a), 32'(ea));
    chk("dm_wd", dm_wd, ewd);
    chk("dm_Funct3", 32'(dm_Funct3), 32'(ef3));
    if (rd) begin
      for (int k = 0; k < sz(lf); k++) begin
        chk("ld_byte", 32'(dmem[(int'(dm_a) + k) % 512]), 32'(gmem[la + k]));
      end
    end
    we  = dm_MemWrite;
    wa  = dm_a;
    wwd = dm_wd;
    wf3 = dm_Funct3;
    @(posedge clk);
    commit_dut_write(we, wa, wwd, wf3);
    if (drain) begin
      for (int k = 0; k < sz(q[0].f3); k++) gmem[q[0].addr + k] = q[0].data[8*k +: 8];
      void'(q.pop_front());
    end
    if (push) q.push_back('{addr: sa, data: sd, f3: sf});
  endtask

  task automatic do_reset();
    bit          we;
    logic [8:0]  wa;
    logic [31:0] wwd;
    logic [2:0]  wf3;
    @(negedge clk);
    reset    = 1'b1;
    st_valid = 1'b0;
    ld_req   = 1'b0;
    #1;
    we  = dm_MemWrite;
    wa  = dm_a;
    wwd = dm_wd;
    wf3 = dm_Funct3;
    @(posedge clk);
    commit_dut_write(we, wa, wwd, wf3);
    q.delete();
    #1 reset = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 0, 32'h0, 3'b000, 1'b0, 0, 3'b000);
  endtask

  initial begin
    logic [2:0] lf3s[5];
    lf3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 512; i++) begin
      dmem[i] = 8'h00;
      gmem[i] = 8'h00;
    end
    reset = 1'b1; st_valid = 1'b0; ld_req = 1'b0;
    st_addr = '0; st_data = '0; st_funct3 = '0; ld_addr = '0; ld_funct3 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();

    // Three stores held back by non-conflicting loads, then reset discards them.
    step(1'b1, 'h100, 32'h11111111, 3'b010, 1'b1, 'h1F0, 3'b010);
    step(1'b1, 'h104, 32'h22222222, 3'b010, 1'b1, 'h1F0, 3'b010);
    step(1'b1, 'h108, 32'h33333333, 3'b010, 1'b1, 'h1F0, 3'b010);
    do_reset();
    idle();
    for (int a = 'h100; a < 'h10C; a++) chk("reset_discard", 32'(dmem[a]), 32'(gmem[a]));

    // Single SW, then idle: drains the next cycle, empty after.
    step(1'b1, 'h010, 32'hDEADBEEF, 3'b010, 1'b0, 0, 3'b000);
    idle();
    idle();

    // Fill with loads held to a distant address; full forces a drain and stalls the load.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 'h080 + 4 * i, 32'hA0000000 + 32'(i), 3'b010, 1'b1, 'h1F0, 3'b010);
    end
    step(1'b1, 'h090, 32'hA5A5A5A5, 3'b010, 1'b1, 'h1F0, 3'b010);
    step(1'b1, 'h090, 32'hA5A5A5A5, 3'b010, 1'b1, 'h1F0, 3'b010);
    repeat (5) idle();

    // SB 0xAA @0x021 pending, LW @0x020 stalls until it drains, then reads it.
    step(1'b1, 'h021, 32'h000000AA, 3'b000, 1'b0, 0, 3'b000);
    repeat (3) step(1'b0, 0, 32'h0, 3'b000, 1'b1, 'h020, 3'b010);
    chk("byte1_AA", 32'(dmem['h021]), 32'hAA);

    // SH @0x030 pending, LB @0x032 is adjacent and proceeds immediately.
    step(1'b1, 'h030, 32'h0000BEEF, 3'b001, 1'b0, 0, 3'b000);
    step(1'b0, 0, 32'h0, 3'b000, 1'b1, 'h032, 3'b000);
    idle();
    idle();

    // Push and pop together at count 2 across the pointer wrap.
    step(1'b1, 'h0C0, 32'hC0C0C0C0, 3'b010, 1'b1, 'h1F0, 3'b010);
    step(1'b1, 'h0C4, 32'hC4C4C4C4, 3'b010, 1'b1, 'h1F0, 3'b010);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 'h0C8 + 4 * i, 32'hD0000000 + 32'(i), 3'b010, 1'b0, 0, 3'b000);
    end
    repeat (3) idle();

    // Random traffic over a small window to provoke overlaps.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 'h040 + int'($urandom_range(0, 15)), $urandom,
           3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 'h040 + int'($urandom_range(0, 15)),
           lf3s[$urandom_range(0, 4)]);
    end
    repeat (6) idle();
    for (int a = 0; a < 512; a++) begin
      if (dmem[a] !== gmem[a]) chk("mem_final", 32'(dmem[a]), 32'(gmem[a]));
    end
    chk("mem_final_040", {dmem['h043], dmem['h042], dmem['h041], dmem['h040]},
        {gmem['h043], gmem['h042], gmem['h041], gmem['h040]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
